cla32: RTL and testbench
========================

Name: cla32

Overview:
- 32-bit carry-lookahead adder computing a + b + cin, with a 33-bit result (bit 32 = carry-out).
- Serves as the add/subtract datapath of the ALU.
- Subtraction: the caller presents ~b with cin=1.
- Combinational lookahead core; result and valid flag are registered, giving fixed 1-cycle latency.

Parameters:
- None. Width fixed at 32; group size 4 is a package constant.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  32  addend A
- b  input  32  addend B (already inverted by caller for subtract)
- cin  input  1  carry-in into bit 0
- in_valid  input  1  operands valid this cycle
- out  output  33  registered sum; out[31:0] = sum, out[32] = carry-out
- out_valid  output  1  out holds the result of operands accepted on the previous edge

Behaviour:
- Reset: while rst_n=0, asynchronously force out=33'h0 and out_valid=0. Outputs hold these values until the first rising edge after deassertion.
- Each rising edge with rst_n=1:
  - out <= {carry-out, sum} of the current a, b, cin, regardless of in_valid.
  - out_valid <= in_valid.
- Latency is exactly 1 cycle. No stall or backpressure; accepts new operands every cycle.
- Arithmetic:
  - Unsigned modular 33-bit result: out = zero-extended a + zero-extended b + cin.
  - Signed interpretation is the caller's concern; no overflow flag is produced.
- Lookahead structure:
  - Bit level: g_i = a_i & b_i; p_i = a_i ^ b_i.
  - 8 groups of 4 bits, each producing group generate G and group propagate P.
  - A second-level lookahead unit computes group carries c_4k directly from G, P and cin; no ripple between groups.
  - Sum bit: s_i = p_i ^ c_i.
  - Carry-out: c_32 = G_hi | P_hi & c_28.
- Boundary cases:
  - All-ones + 0 + cin=1 gives a full carry chain: result 0x1_0000_0000.
  - 0 + 0 + 0 gives 0.
  - All-ones + all-ones + 1 gives 0x1_FFFF_FFFF.
- Reset asserted mid-stream: the pending result is discarded and out_valid=0. The first valid result appears one cycle after the first edge with in_valid=1 following reset release.
- Unknown (X/Z) inputs are not sanitized; they propagate.

Decomposition:
- Shared package cla_pkg:
  - localparam CLA_WIDTH=32, CLA_GROUP=4, CLA_NGROUPS=8.
  - typedef logic [CLA_WIDTH-1:0] word_t.
  - typedef logic [CLA_WIDTH:0] sum_t.
- One sub-module, cla4_group:
  - Inputs: 4-bit a, 4-bit b, carry-in.
  - Outputs: 4-bit sum, group G, group P.
  - Instantiated 8 times.
- The second-level carry unit and output register stay in cla32.

Test Plan:
- Reset: hold rst_n=0 with a=0xFFFFFFFF, b=1 -> out=0, out_valid=0. Release; first edge with in_valid=1 -> out_valid=1 next cycle.
- a=3, b=0xFFFFFFFF, cin=0, in_valid=1 -> one cycle later out=0x1_0000_0002, out_valid=1.
- Subtract 3-1: a=3, b=0xFFFFFFFE, cin=1 -> out=0x1_0000_0002. Subtract 1-3: a=1, b=0xFFFFFFFC, cin=1 -> out=0x0_FFFF_FFFE.
- Full carry chain: a=0xFFFFFFFF, b=0, cin=1 -> out=0x1_0000_0000. Also a=b=0xFFFFFFFF, cin=1 -> out=0x1_FFFF_FFFF.
- Back-to-back: new operands every cycle with in_valid toggling 1,0,1 -> out tracks each sum one cycle later; out_valid sequence is 1,0,1.
- 10,000 random {a, b, cin} -> out equals the behavioural 33-bit a+b+cin of the prior cycle. Assert rst_n low mid-run -> out=0 and out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and types for the 32-bit carry-lookahead adder.
// The design is 8 groups of 4 bits.
package cla_pkg;

    localparam int CLA_WIDTH   = 32;
    localparam int CLA_GROUP   = 4;
    localparam int CLA_NGROUPS = CLA_WIDTH / CLA_GROUP;

    typedef logic [CLA_WIDTH-1:0] word_t;
    typedef logic [CLA_WIDTH:0]   sum_t;

endpackage

// File: rtl/cla4_group.sv
// 4-bit lookahead group. It produces the sum bits from the incoming group carry,
// plus the group generate/propagate used by the second-level carry unit.
module cla4_group
    import cla_pkg::*;
(
    input  logic [CLA_GROUP-1:0] a_i,
    input  logic [CLA_GROUP-1:0] b_i,
    input  logic                 c_i,
    output logic [CLA_GROUP-1:0] s_o,
    output logic                 g_o,
    output logic                 p_o
);

    logic [CLA_GROUP-1:0] g;
    logic [CLA_GROUP-1:0] p;
    logic [CLA_GROUP-1:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Each internal carry is a flat sum of products of c_i, so nothing ripples inside the group.
    assign c[0] = c_i;
    assign c[1] = g[0] | (p[0] & c_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);

    assign s_o = p ^ c;
    assign g_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign p_o = &p;

endmodule

// File: rtl/cla32.sv
// 32-bit two-level carry-lookahead adder: out = a + b + cin.
// The result and its valid flag are registered, giving a fixed 1-cycle latency.
module cla32
    import cla_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  word_t a,
    input  word_t b,
    input  logic  cin,
    input  logic  in_valid,
    output sum_t  out,
    output logic  out_valid
);

    logic [CLA_NGROUPS-1:0] grp_g;
    logic [CLA_NGROUPS-1:0] grp_p;
    logic [CLA_NGROUPS-1:0] grp_c;
    word_t                  sum;
    logic                   cout;
    sum_t                   out_d;
    sum_t                   out_q;
    logic                   out_valid_q;

    for (genvar gi = 0; gi < CLA_NGROUPS; gi++) begin : g_grp
        cla4_group u_grp (
            .a_i (a[gi*CLA_GROUP +: CLA_GROUP]),
            .b_i (b[gi*CLA_GROUP +: CLA_GROUP]),
            .c_i (grp_c[gi]),
            .s_o (sum[gi*CLA_GROUP +: CLA_GROUP]),
            .g_o (grp_g[gi]),
            .p_o (grp_p[gi])
        );
    end

    // Group carry c_4k = OR over j<k of (G_j & P_j+1..P_k-1), OR (P_0..P_k-1 & cin).
    // Every term is formed independently, so the carries do not ripple between groups.
    always_comb begin
        logic acc;
        logic term;
        // NOTE: the scratch variables get a value before any use, so this block infers no latch.
        acc   = 1'b0;
        term  = 1'b0;
        grp_c = '0;
        for (int k = 0; k < CLA_NGROUPS; k++) begin
            acc = cin;
            for (int j = 0; j < k; j++) begin
                acc = acc & grp_p[j];
            end
            for (int j = 0; j < k; j++) begin
                term = grp_g[j];
                for (int m = j + 1; m < k; m++) begin
                    term = term & grp_p[m];
                end
                acc = acc | term;
            end
            grp_c[k] = acc;
        end
    end

    assign cout  = grp_g[CLA_NGROUPS-1] | (grp_p[CLA_NGROUPS-1] & grp_c[CLA_NGROUPS-1]);
    assign out_d = {cout, sum};

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= in_valid;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cla32.sv
// Self-checking bench for cla32. It applies a table of directed vectors, then
// 10,000 random operands compared with a plain-arithmetic model, plus reset checks.
module tb_cla32;
    import cla_pkg::*;

    logic  clk;
    logic  rst_n;
    word_t a;
    word_t b;
    logic  cin;
    logic  in_valid;
    sum_t  out;
    logic  out_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        word_t a;
        word_t b;
        logic  cin;
        logic  in_valid;
        sum_t  exp_out;
        logic  exp_valid;
    } vec_t;

    vec_t vecs[10];

    cla32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic sum_t ref_add(input word_t x, input word_t y, input logic c);
        return 33'(x) + 33'(y) + 33'(c);
    endfunction

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, let one rising edge pass, and check 2 time units later.
    task automatic step(input string name, input word_t av, input word_t bv, input logic cv,
                        input logic vv, input sum_t exp_out, input logic exp_v);
        @(negedge clk);
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = vv;
        @(posedge clk);
        #2;
        check({name, " out"}, out, exp_out);
        check({name, " valid"}, {32'd0, out_valid}, {32'd0, exp_v});
    endtask

    initial begin
        word_t ra;
        word_t rb;
        logic  rc;
        logic  rv;

        vecs[0] = '{"add_wrap",   32'h0000_0003, 32'hFFFF_FFFF, 1'b0, 1'b1, 33'h1_0000_0002, 1'b1};
        vecs[1] = '{"sub_3m1",    32'h0000_0003, 32'hFFFF_FFFE, 1'b1, 1'b1, 33'h1_0000_0002, 1'b1};
        vecs[2] = '{"sub_1m3",    32'h0000_0001, 32'hFFFF_FFFC, 1'b1, 1'b1, 33'h0_FFFF_FFFE, 1'b1};
        vecs[3] = '{"full_chain", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 33'h1_0000_0000, 1'b1};
        vecs[4] = '{"all_ones",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 33'h1_FFFF_FFFF, 1'b1};
        vecs[5] = '{"zero",       32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 33'h0_0000_0000, 1'b1};
        vecs[6] = '{"grp_carry",  32'h0000_000F, 32'h0000_0001, 1'b0, 1'b1, 33'h0_0000_0010, 1'b1};
        vecs[7] = '{"b2b_0",      32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 33'h0_2345_6789, 1'b1};
        vecs[8] = '{"b2b_1",      32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 33'h1_0000_0000, 1'b0};
        vecs[9] = '{"b2b_2",      32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, 33'h0_0001_0000, 1'b1};

        // Reset held with live operands: outputs must stay cleared across rising edges.
        rst_n    = 1'b0;
        a        = 32'hFFFF_FFFF;
        b        = 32'h0000_0001;
        cin      = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("reset out", out, 33'h0);
        check("reset valid", {32'd0, out_valid}, 33'h0);

        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_idle", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h1_0000_0000, 1'b0);
        step("post_rst_first", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 33'h0_0000_000C, 1'b1);

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].in_valid,
                 vecs[i].exp_out, vecs[i].exp_valid);
        end

        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            rv = (i == 5000) ? 1'b1 : 1'($urandom_range(0, 1));
            step("random", ra, rb, rc, rv, ref_add(ra, rb, rc), rv);
            if (i == 5000) begin
                // Assert reset between edges: outputs must clear without waiting for a clock.
                @(negedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                check("midrun_reset out", out, 33'h0);
                check("midrun_reset valid", {32'd0, out_valid}, 33'h0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
